fifo_sync_ctrl: RTL
===================

Name: fifo_sync_ctrl

Overview:
- Parametrised synchronous FIFO: pointer/flag controller plus dual-port register-file storage, single clock domain.
- Replaces the bare 8-entry RAM-only buffer. Adds:
  - pointer management;
  - full, empty and almost-full/almost-empty flags;
  - occupancy count;
  - arbitrary power-of-two depth.
- Sits between wide-word producers and consumers (default 384-bit words) in the datapath.

Parameters:
- DATA_WIDTH, 384: word width in bits.
- ADDR_WIDTH, 3: depth = 2**ADDR_WIDTH entries; legal range 2..10.
- AFULL_THRESH, 2**ADDR_WIDTH-1: almost_full asserts when count >= this value.
- AEMPTY_THRESH, 1: almost_empty asserts when count <= this value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  no free entries.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  head-of-queue word (show-ahead).
- empty  out  1  no valid entries.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  sticky error flag (see Optional Feature).
- underflow  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - reset=1 at a rising edge clears wr_ptr, rd_ptr, overflow and underflow.
  - After reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0, rd_data=0.
  - Storage contents are not cleared; rd_data is gated to 0 while empty, so stale data never escapes.
  - Reset mid-operation discards all contents. Any wr_en/rd_en in the reset cycle is ignored.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address storage; the MSB is the wrap bit.
  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- Flags and count:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal AND MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - All flags are decoded from registered pointers only; no combinational path from wr_en/rd_en to any flag.
- Write accept:
  - wr_ok = wr_en & (~full | rd_ok).
  - On wr_ok, mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data and wr_ptr increments at the next edge.
- Read accept:
  - rd_ok = rd_en & ~empty.
  - rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]] combinationally (zero-latency show-ahead).
  - On rd_ok, rd_ptr increments.
- Latency:
  - A word written at edge N is visible on rd_data, with empty=0, after edge N.
  - Write-to-read latency is 1 cycle.
- Simultaneous read and write:
  - When full: both are accepted; count is unchanged and full stays 1.
  - When empty: the write is accepted, the read is ignored (no bypass); count becomes 1.
  - Otherwise: both are accepted; count is unchanged.
- Rejected requests:
  - Write while full without a read, or read while empty, is dropped.
  - Pointers and storage are unchanged.
- Thresholds:
  - Compared against the registered count.
  - Parameter sanity: if AFULL_THRESH > 2**ADDR_WIDTH or AEMPTY_THRESH >= 2**ADDR_WIDTH, elaboration fails via a generate-time error.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets when wr_en & full & ~rd_en.
  - underflow sets when rd_en & empty.
  - Both flags are sticky until reset.
- Undefined:
  - overflow and underflow are tied to 0.
  - No extra flops are generated.
- Port list is identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - function fifo_count_w(addr_w) returning addr_w+1;
  - the localparam for maximum legal ADDR_WIDTH (10).
- One sub-module: fifo_dp_regfile.
  - Ports: clk, w_en, w_addr, w_data, r_addr, r_data.
  - Async read, sync write, no reset.
  - Instantiated once by fifo_sync_ctrl.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then release.
  - Required: empty=1, full=0, count=0, rd_data=0, almost_empty=1.
- Fill to full (ADDR_WIDTH=3):
  - Stimulus: write 8 words 0x01..0x08.
  - Required: full=1 and count=8 after the 8th edge; almost_full=1 from count=7.
  - A 9th write is dropped, count stays 8, and overflow=1 with the macro defined.
- Drain in order:
  - Stimulus: from full, assert rd_en for 8 cycles.
  - Required: rd_data shows 0x01..0x08 in order; empty=1 after the 8th edge.
  - A further rd_en sets underflow=1 with the macro defined.
- Simultaneous read and write at the boundaries:
  - When full: count stays 8, head advances, the new word lands at the tail.
  - When empty: count becomes 1 and rd_data shows the written word one cycle later.
- Wrap-around:
  - Stimulus: 20 cycles of interleaved single write/read on depth 8.
  - Required: pointers pass the wrap bit, data order is preserved, count stays within 0..1.
- Reset mid-operation:
  - Stimulus: count=5, then reset=1 together with wr_en=1.
  - Required: next cycle count=0, empty=1, the write is ignored and error flags are cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller and its storage.
//   fifo_count_w    : width of occupancy count/pointers for a given address width
//   FIFO_MAX_ADDR_W : largest supported ADDR_WIDTH
package fifo_pkg;

    localparam int unsigned FIFO_MIN_ADDR_W = 2;
    localparam int unsigned FIFO_MAX_ADDR_W = 10;

    // Pointers and count carry one extra wrap bit above the storage address.
    function automatic int unsigned fifo_count_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_dp_regfile.sv
// Dual-port register file used as FIFO storage.
// Ports:
//   clk    : rising-edge clock
//   w_en   : write strobe, w_data stored at w_addr on the clock edge
//   w_addr : write address
//   w_data : write word
//   r_addr : read address
//   r_data : asynchronous read data at r_addr
// No reset: contents are undefined until written.
module fifo_dp_regfile
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 384,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // Asynchronous read port.
    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Parametrised single-clock FIFO: pointer/flag controller plus register-file storage.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data      : push request and word
//   rd_en               : pop request
//   rd_data             : head-of-queue word (show-ahead), 0 while empty
//   full, empty         : occupancy flags
//   almost_full/empty   : count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count               : occupancy 0..2**ADDR_WIDTH
//   overflow, underflow : sticky error flags
// Build option: define FIFO_ERR_FLAGS_EN to implement the sticky overflow/underflow
// flags; otherwise they are tied to 0 and no flops are built for them.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 384,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 full,
    output logic                                 almost_full,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 empty,
    output logic                                 almost_empty,
    output logic [fifo_count_w(ADDR_WIDTH)-1:0]  count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int unsigned CNT_W = fifo_count_w(ADDR_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Elaboration-time parameter sanity.
    generate
        if (ADDR_WIDTH < FIFO_MIN_ADDR_W || ADDR_WIDTH > FIFO_MAX_ADDR_W) begin : g_bad_addr_w
            $error("fifo_sync_ctrl: ADDR_WIDTH out of legal range");
        end
        if (AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("fifo_sync_ctrl: AFULL_THRESH exceeds depth");
        end
        if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
            $error("fifo_sync_ctrl: AEMPTY_THRESH must be below depth");
        end
    endgenerate

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags decoded purely from registered pointers.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                          (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_dp_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .w_en   (wr_ok & ~reset),
        .w_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .w_data (wr_data),
        .r_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .r_data (mem_rdata)
    );

    // Storage is never cleared, so mask stale words while empty.
    assign rd_data = empty ? '0 : mem_rdata;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error capture until reset.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full & ~rd_en);
        underflow_d = underflow_q | (rd_en & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
